// File: rtl/sonar_frame_scheduler.sv
// Doppler frame sequencer: transmit burst, ring-down blanking, FFT_LEN-sample capture,
// then a bounded wait for the FFT peak; reports peak or timeout once per frame.
module sonar_frame_scheduler #(
  parameter int unsigned FFT_LEN        = 2048,
  parameter int unsigned BURST_CYCLES   = 1000,
  parameter int unsigned BLANK_CYCLES   = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned GAP_CYCLES     = 10000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        enable_in,
  input  logic        adc_valid_in,
  input  logic [15:0] adc_data_in,
  input  logic        peak_valid_in,
  input  logic [31:0] peak_freq_in,
  output logic        tx_en_out,
  output logic        fft_ce_out,
  output logic [15:0] fft_sample_out,
  output logic        result_valid_out,
  output logic [31:0] result_freq_out,
  output logic        timeout_out,
  output logic        busy_out,
  output logic [15:0] frame_count_out
);

  localparam int unsigned MAX_AB  = (FFT_LEN > BURST_CYCLES) ? FFT_LEN : BURST_CYCLES;
  localparam int unsigned MAX_CD  = (BLANK_CYCLES > GAP_CYCLES) ? BLANK_CYCLES : GAP_CYCLES;
  localparam int unsigned MAX_ABCD = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned MAX_ALL = (MAX_ABCD > TIMEOUT_CYCLES) ? MAX_ABCD : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_ALL + 1);

  // Each phase counts down from (length - 1) to zero
  localparam logic [CNT_W-1:0] BURST_LOAD   = CNT_W'(BURST_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD   = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CAPTURE_LOAD = CNT_W'(FFT_LEN - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX,
    S_BLANK,
    S_CAPTURE,
    S_WAIT_PEAK,
    S_REPORT,
    S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sample_take;
  logic             peak_take;
  logic             timeout_hit;
  logic             tx_en_d;
  logic             busy_d;
  logic             frame_done;

  // Next-state, phase counter and registered-output next values
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sample_take = 1'b0;
    peak_take   = 1'b0;
    timeout_hit = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable_in) begin
          state_d = S_TX;
          cnt_d   = BURST_LOAD;
        end
      end
      S_TX: begin
        if (cnt_q == '0) begin
          state_d = S_BLANK;
          cnt_d   = BLANK_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_BLANK: begin
        if (cnt_q == '0) begin
          state_d = S_CAPTURE;
          cnt_d   = CAPTURE_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_CAPTURE: begin
        if (adc_valid_in) begin
          sample_take = 1'b1;
          if (cnt_q == '0) begin
            state_d = S_WAIT_PEAK;
            cnt_d   = TIMEOUT_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      S_WAIT_PEAK: begin
        // A peak on the final wait cycle still beats the timeout
        if (peak_valid_in) begin
          peak_take = 1'b1;
          state_d   = S_REPORT;
          cnt_d     = '0;
        end else if (cnt_q == '0) begin
          timeout_hit = 1'b1;
          state_d     = S_GAP;
          cnt_d       = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_REPORT: begin
        state_d = S_GAP;
        cnt_d   = GAP_LOAD;
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          if (enable_in) begin
            state_d = S_TX;
            cnt_d   = BURST_LOAD;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    tx_en_d    = (state_d == S_TX);
    busy_d     = (state_d != S_IDLE);
    frame_done = (state_d == S_GAP) && (state_q != S_GAP);
  end

  // State, counter and output registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      tx_en_out        <= 1'b0;
      fft_ce_out       <= 1'b0;
      fft_sample_out   <= '0;
      result_valid_out <= 1'b0;
      result_freq_out  <= '0;
      timeout_out      <= 1'b0;
      busy_out         <= 1'b0;
      frame_count_out  <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      tx_en_out        <= tx_en_d;
      fft_ce_out       <= sample_take;
      result_valid_out <= peak_take;
      timeout_out      <= timeout_hit;
      busy_out         <= busy_d;
      if (sample_take) fft_sample_out <= adc_data_in;
      if (peak_take) result_freq_out <= peak_freq_in;
      if (frame_done) frame_count_out <= frame_count_out + 16'd1;
    end
  end

endmodule

// File: tb/tb_sonar_frame_scheduler.sv
// Scoreboard bench for sonar_frame_scheduler: directed frames push expected strobes
// into queues, a negedge monitor pops and compares whenever the DUT emits one.
module tb_sonar_frame_scheduler;

  localparam int FFT_LEN = 8;
  localparam int BURST   = 4;
  localparam int BLANK   = 3;
  localparam int TIMEOUT = 20;
  localparam int GAP     = 5;
  localparam int CS      = BURST + BLANK + 1;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        enable_in;
  logic        adc_valid_in;
  logic [15:0] adc_data_in;
  logic        peak_valid_in;
  logic [31:0] peak_freq_in;
  logic        tx_en_out;
  logic        fft_ce_out;
  logic [15:0] fft_sample_out;
  logic        result_valid_out;
  logic [31:0] result_freq_out;
  logic        timeout_out;
  logic        busy_out;
  logic [15:0] frame_count_out;

  typedef struct {
    logic [31:0] val;
    int          cyc;
  } exp_t;

  exp_t sq[$];
  exp_t rq[$];
  exp_t tq[$];

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [15:0] exp_fc = 16'd0;
  logic [31:0] exp_res = 32'd0;

  sonar_frame_scheduler #(
    .FFT_LEN(FFT_LEN),
    .BURST_CYCLES(BURST),
    .BLANK_CYCLES(BLANK),
    .TIMEOUT_CYCLES(TIMEOUT),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .enable_in(enable_in),
    .adc_valid_in(adc_valid_in),
    .adc_data_in(adc_data_in),
    .peak_valid_in(peak_valid_in),
    .peak_freq_in(peak_freq_in),
    .tx_en_out(tx_en_out),
    .fft_ce_out(fft_ce_out),
    .fft_sample_out(fft_sample_out),
    .result_valid_out(result_valid_out),
    .result_freq_out(result_freq_out),
    .timeout_out(timeout_out),
    .busy_out(busy_out),
    .frame_count_out(frame_count_out)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tx_en"}, 32'(tx_en_out), 32'd0);
    check({tag, "_fft_ce"}, 32'(fft_ce_out), 32'd0);
    check({tag, "_fft_sample"}, 32'(fft_sample_out), 32'd0);
    check({tag, "_result_valid"}, 32'(result_valid_out), 32'd0);
    check({tag, "_result_freq"}, result_freq_out, 32'd0);
    check({tag, "_timeout"}, 32'(timeout_out), 32'd0);
    check({tag, "_busy"}, 32'(busy_out), 32'd0);
    check({tag, "_frame_count"}, 32'(frame_count_out), 32'd0);
  endtask

  // Monitor: every output strobe must match the head of its expectation queue
  always @(negedge clk_in) begin
    exp_t e;
    if (fft_ce_out) begin
      if (sq.size() == 0) flag("fft_ce_unexpected");
      else begin
        e = sq.pop_front();
        check("fft_sample", 32'(fft_sample_out), e.val);
        check("fft_ce_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (result_valid_out) begin
      if (rq.size() == 0) flag("result_valid_unexpected");
      else begin
        e = rq.pop_front();
        check("result_freq", result_freq_out, e.val);
        check("result_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (timeout_out) begin
      if (tq.size() == 0) flag("timeout_unexpected");
      else begin
        e = tq.pop_front();
        check("timeout_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // One frame from IDLE. mode 0: adc strobes every cycle; 1: only during capture;
  // 2: every 3rd cycle. peak_d: cycles after WAIT_PEAK entry (-1 = none).
  task automatic run_frame(input int mode, input int peak_d, input logic [31:0] freq,
                           input int drop_k, input int stray_k, input int rst_after);
    int acc, w, endk, tx_hi, tx_bad;
    bit finished, was_reset, av;
    acc = 0; w = -1; endk = -1; tx_hi = 0; tx_bad = 0;
    finished = 1'b0; was_reset = 1'b0;
    enable_in = 1'b1;
    for (int k = 1; k < 400 && !finished && !was_reset; k++) begin
      @(negedge clk_in);
      if (tx_en_out) tx_hi++;
      if (tx_en_out !== ((k <= BURST) ? 1'b1 : 1'b0)) tx_bad++;
      if (k == endk) finished = 1'b1;
      else begin
        adc_valid_in  = 1'b0;
        peak_valid_in = 1'b0;
        if (k == drop_k) enable_in = 1'b0;
        if (rst_after >= 0 && acc == rst_after) begin
          rst_in    = 1'b1;
          enable_in = 1'b0;
          was_reset = 1'b1;
        end else begin
          case (mode)
            0:       av = 1'b1;
            1:       av = (k >= CS) && (w < 0);
            default: av = (k % 3 == 0);
          endcase
          if (av) begin
            adc_valid_in = 1'b1;
            adc_data_in  = 16'($urandom);
            if (k >= CS && w < 0) begin
              acc++;
              sq.push_back('{32'(adc_data_in), cyc + 1});
              if (acc == FFT_LEN) begin
                w = k + 1;
                if (drop_k < 0) enable_in = 1'b0;
              end
            end
          end
          if (k == stray_k) begin
            peak_valid_in = 1'b1;
            peak_freq_in  = 32'd999;
          end
          if (w >= 0 && k >= w && endk < 0) begin
            if (peak_d >= 0 && k == w + peak_d) begin
              peak_valid_in = 1'b1;
              peak_freq_in  = freq;
              rq.push_back('{freq, cyc + 1});
              exp_res = freq;
              endk = k + 2 + GAP;
            end else if (peak_d < 0) begin
              tq.push_back('{32'd0, cyc + TIMEOUT});
              endk = w + TIMEOUT + GAP;
            end
          end
        end
      end
    end
    adc_valid_in  = 1'b0;
    peak_valid_in = 1'b0;
    enable_in     = 1'b0;
    if (was_reset) begin
      @(negedge clk_in);
      check_all_zero("mid_capture_reset");
      rst_in  = 1'b0;
      exp_fc  = 16'd0;
      exp_res = 32'd0;
    end else begin
      if (!finished) flag("frame_never_ended");
      exp_fc = exp_fc + 16'd1;
      check("frame_end_busy", 32'(busy_out), 32'd0);
      check("frame_count", 32'(frame_count_out), 32'(exp_fc));
      check("result_freq_held", result_freq_out, exp_res);
      check("tx_high_cycles", 32'(tx_hi), 32'(BURST));
      check("tx_window_errors", 32'(tx_bad), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_hi;
    rst_in = 1'b1; enable_in = 1'b0; adc_valid_in = 1'b0; adc_data_in = 16'd0;
    peak_valid_in = 1'b0; peak_freq_in = 32'd0;
    repeat (3) @(negedge clk_in);
    check_all_zero("reset");
    rst_in = 1'b0;
    @(negedge clk_in);

    // Continuous ADC strobes incl. TX/BLANK; peak 5 cycles into the wait
    run_frame(0, 5, 32'd40123, -1, -1, -1);
    // No peak: timeout 20 cycles after wait entry, result unchanged
    run_frame(1, -1, 32'd0, -1, -1, -1);
    // Peak on the timeout cycle: peak wins
    run_frame(1, TIMEOUT - 1, 32'd12345, -1, -1, -1);
    // Sparse strobes, stray peak during capture
    run_frame(2, 2, 32'd777, -1, 10, -1);
    // Enable dropped mid-capture: frame completes then stays idle
    run_frame(1, 0, 32'd555, 10, -1, -1);
    busy_hi = 0;
    repeat (10) begin
      @(negedge clk_in);
      if (busy_out || tx_en_out) busy_hi++;
    end
    check("idle_after_drop", 32'(busy_hi), 32'd0);

    // Frame counter wrap
    force dut.frame_count_out = 16'hFFFF;
    @(negedge clk_in);
    release dut.frame_count_out;
    exp_fc = 16'hFFFF;
    run_frame(1, 3, 32'd31337, -1, -1, -1);

    // Reset after 3 captured samples
    run_frame(1, -1, 32'd0, -1, -1, 3);
    repeat (3) @(negedge clk_in);

    check("sample_queue_empty", 32'(sq.size()), 32'd0);
    check("result_queue_empty", 32'(rq.size()), 32'd0);
    check("timeout_queue_empty", 32'(tq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
